// File: rtl/data_memory_arbiter_pkg.sv
// data_memory_arbiter_pkg: shared types and constants for the
// two-port data memory arbiter (state encoding, port count, alignment).
package data_memory_arbiter_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam int NPORTS = 2;
   localparam logic [1:0] ALIGN_MASK = 2'b11;

   function automatic logic [NPORTS-1:0] onehot2(input logic p);
      return p ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// data_memory_arbiter_if: requester and memory-side bus of the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface data_memory_arbiter_if;
   import data_memory_arbiter_pkg::*;

   logic [NPORTS-1:0] req;
   logic [NPORTS-1:0] we;
   logic [31:0]       addr0;
   logic [31:0]       addr1;
   logic [31:0]       wdata0;
   logic [31:0]       wdata1;
   logic [NPORTS-1:0] gnt;
   logic [NPORTS-1:0] rvalid;
   logic              rerr;
   logic [31:0]       rdata;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_idata;
   logic              mem_write;
   logic [31:0]       mem_odata;

   modport slave (
      input  req, we, addr0, addr1, wdata0, wdata1, mem_odata,
      output gnt, rvalid, rerr, rdata, mem_addr, mem_idata, mem_write
   );

   modport master (
      output req, we, addr0, addr1, wdata0, wdata1, mem_odata,
      input  gnt, rvalid, rerr, rdata, mem_addr, mem_idata, mem_write
   );

endinterface

// File: rtl/data_memory_arbiter_rr_pick2.sv
// rr_pick2: combinational round-robin winner select for two ports.
// Ports: req, last, mask (consumed) in; winner, any_req out.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   input  logic [1:0] mask,
   output logic       winner,
   output logic       any_req
);

   logic [1:0] eff;

   assign eff     = req & ~mask;
   assign any_req = |eff;

   always_comb begin
      winner = 1'b0;
      unique case (1'b1)
         (eff == 2'b01): winner = 1'b0;
         (eff == 2'b10): winner = 1'b1;
         (eff == 2'b11): winner = ~last;
         default:        winner = 1'b0;
      endcase
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin share of one data memory by two ports.
// Ports: clock, reset (async, active-low), bus (slave modport).
module data_memory_arbiter
   import data_memory_arbiter_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   data_memory_arbiter_if.slave  bus
);

   state_t      state;
   logic        owner;
   logic        last;
   logic [1:0]  rvalid_q;
   logic        rerr_q;
   logic [31:0] rdata_q;

   logic        act;
   logic [1:0]  mask;
   logic        win;
   logic        any;
   logic [31:0] a_o;
   logic [31:0] w_o;
   logic        we_o;
   logic        misal;

   assign act   = (state == ACCESS);
   assign a_o   = owner ? bus.addr1 : bus.addr0;
   assign w_o   = owner ? bus.wdata1 : bus.wdata0;
   assign we_o  = bus.we[owner];
   assign misal = |(a_o[1:0] & ALIGN_MASK);

   // The owner's request is consumed at the end of its access.
   assign mask  = act ? onehot2(owner) : 2'b00;

   rr_pick2 u_pick (
      .req     (bus.req),
      .last    (last),
      .mask    (mask),
      .winner  (win),
      .any_req (any)
   );

   assign bus.gnt       = mask;
   assign bus.mem_addr  = act ? a_o : 32'h0;
   assign bus.mem_idata = act ? w_o : 32'h0;
   assign bus.mem_write = act & we_o & ~misal;
   assign bus.rvalid    = rvalid_q;
   assign bus.rerr      = rerr_q;
   assign bus.rdata     = rdata_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         owner    <= 1'b0;
         last     <= 1'b1;
         rvalid_q <= 2'b00;
         rerr_q   <= 1'b0;
         rdata_q  <= 32'h0;
      end else begin
         rvalid_q <= 2'b00;
         rerr_q   <= 1'b0;
         if (act) begin
            rvalid_q <= onehot2(owner);
            rerr_q   <= misal;
            rdata_q  <= (!misal && !we_o) ? bus.mem_odata : 32'h0;
         end
         if (any) begin
            owner <= win;
            last  <= win;
            state <= ACCESS;
         end else begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: scoreboard bench for data_memory_arbiter.
// Stimulus pushes expected grants/completions; a monitor pops and checks.
module tb_data_memory_arbiter;

   logic clk;
   logic reset;

   data_memory_arbiter_if ifc ();

   data_memory_arbiter dut (
      .clock (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   logic [31:0] mem [8] = '{32'h00000000, 32'h11111111,
                            32'h22222222, 32'h33333333,
                            32'h44444444, 32'h55555555,
                            32'h66666666, 32'h77777777};

   always @(posedge clk)
      if (ifc.mem_write) mem[ifc.mem_addr[4:2]] <= ifc.mem_idata;

   assign ifc.mem_odata = mem[ifc.mem_addr[4:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [71:0] gq [$];
   logic [71:0] cq [$];

   task automatic chk(input string nm, input logic [71:0] act,
                      input logic [71:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every grant cycle and every completion pulse.
   always @(negedge clk) begin
      if (ifc.gnt != 2'b00) begin
         if (gq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected grant: got gnt=%b expected none",
                     ifc.gnt);
         end else begin
            chk("grant", {5'b0, ifc.gnt, ifc.mem_write,
                          ifc.mem_addr, ifc.mem_idata}, gq.pop_front());
         end
      end else begin
         chk("idle bus", {39'b0, ifc.mem_write, ifc.mem_addr,
                          ifc.mem_idata}, 72'h0);
      end
      if (ifc.rvalid != 2'b00) begin
         if (cq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected rvalid: got %b expected none",
                     ifc.rvalid);
         end else begin
            chk("completion", {37'b0, ifc.rvalid, ifc.rerr, ifc.rdata},
                cq.pop_front());
         end
      end
   end

   function automatic logic [1:0] oh(input logic p);
      return p ? 2'b10 : 2'b01;
   endfunction

   task automatic push(input logic p, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic er, input logic [31:0] rd);
      gq.push_back({5'b0, oh(p), wr, a, wd});
      cq.push_back({37'b0, oh(p), er, rd});
   endtask

   task automatic drive(input logic p, input logic w,
                        input logic [31:0] a, input logic [31:0] wd);
      if (p) begin
         ifc.we[1] = w;
         ifc.addr1 = a;
         ifc.wdata1 = wd;
      end else begin
         ifc.we[0] = w;
         ifc.addr0 = a;
         ifc.wdata0 = wd;
      end
   endtask

   // One access; req drops in the cycle after the grant is seen.
   task automatic single(input logic p, input logic w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic er, input logic [31:0] rd);
      bit seen;
      seen = 0;
      push(p, w & ~er, a, wd, er, rd);
      drive(p, w, a, wd);
      ifc.req[p] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ifc.gnt[p]) begin
            seen = 1;
            break;
         end
      end
      if (!seen) chk("grant timeout", 72'h0, 72'h1);
      @(posedge clk);
      #1;
      ifc.req[p] = 1'b0;
      tick();
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, " gnt"},       {70'b0, ifc.gnt}, 72'h0);
      chk({tag, " rvalid"},    {70'b0, ifc.rvalid}, 72'h0);
      chk({tag, " rerr"},      {71'b0, ifc.rerr}, 72'h0);
      chk({tag, " rdata"},     {40'b0, ifc.rdata}, 72'h0);
      chk({tag, " mem_write"}, {71'b0, ifc.mem_write}, 72'h0);
      chk({tag, " mem_addr"},  {40'b0, ifc.mem_addr}, 72'h0);
      chk({tag, " mem_idata"}, {40'b0, ifc.mem_idata}, 72'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      #1;
      reset_checks("rerst");
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   initial begin
      reset = 1'b0;
      ifc.req = 2'b00;
      ifc.we = 2'b00;
      ifc.addr0 = 32'h0;
      ifc.addr1 = 32'h0;
      ifc.wdata0 = 32'h0;
      ifc.wdata1 = 32'h0;
      #3;
      reset_checks("reset");
      #9;
      reset = 1'b1;
      tick();

      // Store then load back through port 0.
      single(1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 1'b0, 32'h0);
      single(1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 32'hDEADBEEF);

      // Contention right after reset: port 0 first, then alternate.
      do_reset();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 32'h4, 32'h0);
      push(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h00000000);
      push(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h11111111);
      push(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h00000000);
      push(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h11111111);
      ifc.req = 2'b11;
      repeat (4) tick();
      ifc.req = 2'b00;
      repeat (3) tick();

      // Port 0 held alone: a grant every other cycle.
      drive(1'b0, 1'b0, 32'h8, 32'h0);
      repeat (3) push(1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 32'hDEADBEEF);
      ifc.req = 2'b01;
      repeat (5) tick();
      ifc.req = 2'b00;
      repeat (3) tick();

      // Misaligned store is rejected; word 1 keeps its value.
      single(1'b1, 1'b1, 32'h6, 32'hCAFE, 1'b1, 32'h0);
      single(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h11111111);

      // Reset in the middle of a store access.
      drive(1'b0, 1'b1, 32'h10, 32'h1234);
      ifc.req = 2'b01;
      @(posedge clk);
      #2;
      chk("mid gnt", {70'b0, ifc.gnt}, 72'h1);
      chk("mid mem_write", {71'b0, ifc.mem_write}, 72'h1);
      reset = 1'b0;
      #1;
      chk("abort gnt", {70'b0, ifc.gnt}, 72'h0);
      chk("abort mem_write", {71'b0, ifc.mem_write}, 72'h0);
      ifc.req = 2'b00;
      @(negedge clk);
      reset = 1'b1;
      tick();
      single(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'h44444444);

      // 0x24 aliases word 1.
      single(1'b0, 1'b1, 32'h24, 32'h55, 1'b0, 32'h0);
      single(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h55);

      repeat (4) tick();
      chk("grant queue drained", {40'b0, 32'(gq.size())}, 72'h0);
      chk("completion queue drained", {40'b0, 32'(cq.size())}, 72'h0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
